// File: rtl/row_bias_if.sv
// row_bias_if: row-level request/response bundle between the tiles and the bias provider
`ifndef GRID_LEN
`define GRID_LEN 9
`endif
interface row_bias_if #(parameter int GRID_LEN = `GRID_LEN);
  logic                reshuffle;
  logic                rq_valtotry;
  logic [GRID_LEN-1:0] biasidx;
  logic [GRID_LEN-1:0] valtotry;
  logic                ready;
  modport master (output reshuffle, rq_valtotry, biasidx, input valtotry, ready);
  modport slave (input reshuffle, rq_valtotry, biasidx, output valtotry, ready);
endinterface

// File: rtl/row_bias.sv
// row_bias: LFSR-shuffled symbol order for one grid row, mapping 1-hot try-indexes to 1-hot candidate values
`ifndef GRID_LEN
`define GRID_LEN 9
`endif
module row_bias #(
  parameter int GRID_LEN = `GRID_LEN,
  parameter int LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1,
  localparam int IDX_W = $clog2(GRID_LEN)
) (
  input logic       clock,
  input logic       reset,
  row_bias_if.slave bus
);
  typedef enum logic {SHUFFLE, READY} state_t;
  state_t              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [IDX_W-1:0]    i_q, i_d;
  logic [IDX_W-1:0]    perm_q [GRID_LEN];
  logic [IDX_W-1:0]    perm_d [GRID_LEN];
  logic [GRID_LEN-1:0] valtotry_q, valtotry_d, hit, seen;
  logic [IDX_W-1:0]    j;
  logic                fb, take;
  assign j = lfsr_q[IDX_W-1:0];
  assign fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  assign take = j <= i_q;
  assign bus.valtotry = valtotry_q;
  assign bus.ready = state_q == READY;
  // Candidate lookup: OR of the 1-hot symbols of every selected slot, plus a coverage mask of perm
  always_comb begin
    hit = '0;
    seen = '0;
    for (int k = 0; k < GRID_LEN; k++) begin
      if (bus.biasidx[k]) hit = hit | (GRID_LEN'(1) << perm_q[k]);
      seen = seen | (GRID_LEN'(1) << perm_q[k]);
    end
  end
  // One Fisher-Yates step per SHUFFLE cycle; requests and reshuffle are honoured in READY
  always_comb begin
    state_d = state_q;
    lfsr_d = lfsr_q;
    i_d = i_q;
    perm_d = perm_q;
    valtotry_d = bus.rq_valtotry ? ((state_q == READY && $onehot(bus.biasidx)) ? hit : '0) : valtotry_q;
    if (state_q == SHUFFLE) begin
      lfsr_d = {fb, lfsr_q[LFSR_W-1:1]};
      if (take) begin
        perm_d[i_q] = perm_q[j];
        perm_d[j] = perm_q[i_q];
        i_d = i_q - IDX_W'(1);
        state_d = i_q == IDX_W'(1) ? READY : SHUFFLE;
      end
    end else if (bus.reshuffle) begin
      i_d = IDX_W'(GRID_LEN - 1);
      state_d = SHUFFLE;
    end
  end
  // State registers; reset restores the identity order and reloads the seed
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SHUFFLE;
      lfsr_q <= SEED == '0 ? LFSR_W'(1) : SEED;
      i_q <= IDX_W'(GRID_LEN - 1);
      valtotry_q <= '0;
      for (int k = 0; k < GRID_LEN; k++) perm_q[k] <= IDX_W'(k);
    end else begin
      state_q <= state_d;
      lfsr_q <= lfsr_d;
      i_q <= i_d;
      valtotry_q <= valtotry_d;
      perm_q <= perm_d;
    end
  end
  // Simulation checks: a request index must be 1-hot or zero, and perm must stay a permutation
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!bus.rq_valtotry || $onehot0(bus.biasidx));
      assert (&seen);
    end
  end
endmodule

// File: doc/row_bias.md
Name: row_bias

Overview:
- Value-bias provider for one grid row; sits directly downstream of each tile's `rq_valtotry`/`biasidx` outputs and feeds each tile's `valtotry` input.
- Holds a pseudo-random permutation of the `GRID_LEN` symbols, built by an LFSR-driven Fisher-Yates shuffle after reset.
- Translates a tile's 1-hot try-index into a 1-hot candidate value, so every tile in the row walks the same shuffled symbol order.
- Row-level glue ORs the per-tile request and index lines; non-requesting tiles drive zeros.

Parameters:
- `GRID_LEN`, default `` `GRID_LEN `` (9 for order 3): number of symbols; valid range 2..64.
- `LFSR_W`, default 16: LFSR width; must be ≥ `IDX_W`+1.
- `SEED`, default `16'hACE1`: LFSR load value at reset; a value of 0 is replaced by 1.
- `IDX_W`, derived, `$clog2(GRID_LEN)`: width of a stored symbol number.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `reshuffle`  in  1  pulse: build a new permutation; accepted only in READY.
- `rq_valtotry`  in  1  OR of all row tiles' requests.
- `biasidx`  in  GRID_LEN  OR of all row tiles' indexes; 1-hot or zero.
- `valtotry`  out  GRID_LEN  registered 1-hot candidate value, or zero.
- `ready`  out  1  high when the permutation is stable and requests are serviced.

Behaviour:
- Storage: `perm[0..GRID_LEN-1]`, each `IDX_W` bits (symbol number); 16-bit-class LFSR `lfsr`; shuffle counter `i` (`IDX_W` bits).
- Reset (edge with `reset`=1, overrides everything):
  - `perm[k]` <= k (identity); `lfsr` <= SEED (or 1 if SEED is 0); `i` <= GRID_LEN-1.
  - `valtotry` <= 0; state <= SHUFFLE; `ready` = 0.
- LFSR: Fibonacci, polynomial x^16+x^14+x^13+x^11+1 for `LFSR_W`=16; shifts once on every SHUFFLE cycle and holds in READY. It never reaches 0.
- States are SHUFFLE and READY; `ready` = (state == READY), Moore output.
- SHUFFLE, each cycle:
  - j = `lfsr[IDX_W-1:0]` of the current value.
  - If j ≤ i: swap `perm[i]` and `perm[j]` (j == i is a legal no-op swap).
    - If i == 1, go to READY; otherwise i <= i-1.
  - If j > i: reject. No swap, i unchanged, stay in SHUFFLE.
  - Termination is guaranteed because the maximal-length LFSR visits every nonzero pattern.
  - Minimum shuffle duration is GRID_LEN-1 cycles.
- READY, request service:
  - On an edge with `rq_valtotry`=1, `valtotry` <= onehot(`perm[k]`), where k is the set bit of `biasidx`.
  - Response latency is exactly 1 cycle: valid in the cycle after the request, which is the requester's load cycle.
  - `valtotry` holds its value until the next request or reset. It is not cleared between requests.
  - `biasidx` == 0 with a request: `valtotry` <= 0.
  - `biasidx` not 1-hot (multiple bits set) is illegal. The design must produce `valtotry` <= 0 and flag an assertion failure in simulation.
  - `rq_valtotry`=0: `biasidx` is ignored; `valtotry` holds.
- Reshuffle:
  - `reshuffle`=1 in READY: i <= GRID_LEN-1 and state <= SHUFFLE. `perm` is not re-initialised; the shuffle continues from the current order.
  - `reshuffle` and `rq_valtotry` on the same edge: the request is serviced from the old permutation, then shuffling starts.
  - `reshuffle` during SHUFFLE is ignored.
- Request while not READY: `valtotry` <= 0. The requesting tile sees zero and treats the value as rejected.
- Reset in the middle of a shuffle: the partially shuffled `perm` is discarded and the identity is restored on the same edge.
- Invariant: `perm` is always a permutation of 0..GRID_LEN-1, including every intermediate cycle.

Test Plan:
1. Reset with SEED=16'hACE1, GRID_LEN=9; hold requests low -> `ready` rises after ≥8 cycles; read back all 9 indexes (1<<0 .. 1<<8) -> 9 distinct 1-hot values covering 9'h1FF; results match the bench's C model of the LFSR plus shuffle bit-for-bit.
2. In READY, `rq_valtotry`=1 with `biasidx`=9'h004 at edge t, then the request drops -> `valtotry` == onehot(`perm[2]`) from t+1, and unchanged at t+2..t+5.
3. Request with `biasidx`=0 -> `valtotry`=0 next cycle. Request during SHUFFLE with `biasidx`=9'h001 -> `valtotry`=0 and `ready`=0.
4. Pulse `reshuffle` together with a request for `biasidx`=9'h010 -> `valtotry` = old onehot(`perm[4]`); `ready` drops the next cycle and returns high; the new permutation is still valid across 9 readbacks.
5. Assert `reset` 3 cycles into a shuffle -> next cycle `valtotry`=0, `ready`=0, `lfsr`=SEED; the shuffle rerun gives the same permutation as scenario 1.
6. Sweep 200 random SEEDs with GRID_LEN=4 and GRID_LEN=16 -> every resulting permutation is valid; shuffle completes within 2^LFSR_W cycles; invariant assertion checked every cycle.
